// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory stage of the 5-stage pipeline. It sits between the EX/MEM and
// MEM/WB pipeline registers. ALU-only instructions pass straight through to
// writeback with one cycle of latency. Loads and stores run a
// request/response transaction on the data-memory port. While a transaction
// is outstanding, the block stalls the upstream stages and feeds bubbles to
// writeback.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, an access that spends TIMEOUT_CYCLES cycles in REQ without
//   a response is aborted. The aborted access retires as a non-writing
//   instruction and raises the sticky mem_err_o flag.
//   When undefined, there is no counter and no mem_err_o port.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles before an access is aborted. Only used with
//                   MEM_TIMEOUT_EN. The minimum value is 2.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous, active-low reset
//   ex_mem_i       EX/MEM register contents (ex_mem_t)
//   mem_wb_o       MEM/WB register (mem_wb_t), registered
//   mem_stall_o    holds EX/MEM and all earlier stages, combinational
//   dmem_req_o     data-memory request, registered
//   dmem_we_o      1 = store, 0 = load, registered
//   dmem_addr_o    word address (alu_result with [1:0] cleared), registered
//   dmem_wdata_o   store data (rs2), registered
//   dmem_rdata_i   load data, only looked at while dmem_rvalid_i = 1
//   dmem_rvalid_i  one-cycle response pulse: read-data valid and write ack
//   mem_err_o      sticky timeout flag (only with MEM_TIMEOUT_EN)
// ---------------------------------------------------------------------------

package mem_stage_pkg;

   // EX/MEM pipeline register, 74 bits
   typedef struct packed {
      logic        valid;
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } ex_mem_t;

   // MEM/WB pipeline register, 39 bits
   typedef struct packed {
      logic        valid;
      logic [31:0] alu_or_mem_val;
      logic [4:0]  rd;
      logic        reg_write;
   } mem_wb_t;

endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  ex_mem_t     ex_mem_i,
   output mem_wb_t     mem_wb_o,
   output logic        mem_stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_rvalid_i
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        mem_err_o
`endif
);

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t      state;

   logic        mem_op;
   logic        op_is_store;

   logic [4:0]  req_rd;
   logic        req_reg_write;
   logic        req_mem_to_reg;

   // A memory op is any valid instruction that reads or writes memory.
   // When both mem_read and mem_write are set, the access is treated as a
   // load, so it is a store only when mem_read is clear.
   assign mem_op      = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);
   assign op_is_store = ex_mem_i.mem_write & ~ex_mem_i.mem_read;

   // mem_to_reg travels with the request so that the latched request is
   // complete. The load path, however, always returns read data, so nothing
   // downstream reads this bit.
   logic unused_mem_to_reg;
   assign unused_mem_to_reg = req_mem_to_reg;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] timeout_cnt;
   logic             timeout_hit;

   // The abort fires in the last allowed REQ cycle, but only when no
   // response arrives in that same cycle. A late response still wins.
   assign timeout_hit = (state == REQ) && !dmem_rvalid_i &&
                        (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

   // Stall generation. In IDLE, a memory op holds upstream for the cycle in
   // which the request is launched. In REQ, upstream is held until the
   // response arrives. The stall drops in the response cycle itself, so the
   // next instruction moves into EX/MEM on the same edge on which this one
   // retires. An aborted access also retires, so the stall releases in the
   // timeout cycle too. Otherwise the dead op would be relaunched from IDLE.
   always_comb begin
      mem_stall_o = 1'b0;
      case (state)
         IDLE: mem_stall_o = mem_op;
         REQ: begin
`ifdef MEM_TIMEOUT_EN
            mem_stall_o = !dmem_rvalid_i && !timeout_hit;
`else
            mem_stall_o = !dmem_rvalid_i;
`endif
         end
         default: mem_stall_o = 1'b0;
      endcase
   end

   // Main FSM, together with every registered output. In IDLE, it either
   // passes an ALU result through to MEM/WB or latches a memory request and
   // moves to REQ with a bubble going to writeback. In REQ, the request
   // fields are held stable until the response arrives. The instruction then
   // retires on the following edge: loads carry the read data and stores
   // carry their address with the register write suppressed. Reset drops any
   // outstanding transaction without a writeback. A response seen in IDLE,
   // for example one that arrives after a reset, is simply ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_wb_o       <= '0;
         dmem_req_o     <= 1'b0;
         dmem_we_o      <= 1'b0;
         dmem_addr_o    <= '0;
         dmem_wdata_o   <= '0;
         req_rd         <= '0;
         req_reg_write  <= 1'b0;
         req_mem_to_reg <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         timeout_cnt    <= '0;
         mem_err_o      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  dmem_req_o     <= 1'b1;
                  dmem_we_o      <= op_is_store;
                  dmem_addr_o    <= {ex_mem_i.alu_result[31:2], 2'b00};
                  dmem_wdata_o   <= ex_mem_i.rs2_data;
                  req_rd         <= ex_mem_i.rd;
                  req_reg_write  <= ex_mem_i.reg_write;
                  req_mem_to_reg <= ex_mem_i.mem_to_reg;
                  mem_wb_o       <= '0;
                  state          <= REQ;
               end else begin
                  mem_wb_o.valid          <= ex_mem_i.valid;
                  mem_wb_o.alu_or_mem_val <= ex_mem_i.alu_result;
                  mem_wb_o.rd             <= ex_mem_i.rd;
                  mem_wb_o.reg_write      <= ex_mem_i.reg_write & ex_mem_i.valid;
               end
            end
            REQ: begin
               if (dmem_rvalid_i) begin
                  dmem_req_o     <= 1'b0;
                  state          <= IDLE;
                  mem_wb_o.valid <= 1'b1;
                  mem_wb_o.rd    <= req_rd;
                  if (dmem_we_o) begin
                     mem_wb_o.alu_or_mem_val <= dmem_addr_o;
                     mem_wb_o.reg_write      <= 1'b0;
                  end else begin
                     mem_wb_o.alu_or_mem_val <= dmem_rdata_i;
                     mem_wb_o.reg_write      <= req_reg_write;
                  end
`ifdef MEM_TIMEOUT_EN
               end else if (timeout_hit) begin
                  dmem_req_o              <= 1'b0;
                  state                   <= IDLE;
                  mem_wb_o.valid          <= 1'b1;
                  mem_wb_o.alu_or_mem_val <= '0;
                  mem_wb_o.rd             <= req_rd;
                  mem_wb_o.reg_write      <= 1'b0;
`endif
               end else begin
                  mem_wb_o <= '0;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef MEM_TIMEOUT_EN
         // The counter sits at zero outside REQ, so it always starts from
         // zero on entry. It advances only on REQ cycles without a response.
         if (state == REQ && !dmem_rvalid_i && !timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end else begin
            timeout_cnt <= '0;
         end
         if (timeout_hit) begin
            mem_err_o <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage. A monitor pops expected MEM/WB words
// from a scoreboard queue whenever the stage retires an instruction. A
// responder process answers data-memory requests after a programmable number
// of REQ cycles, and the read data is derived from the request address.
// Define MEM_TIMEOUT_EN to include the timeout scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   ex_mem_t     ex_mem;
   mem_wb_t     mem_wb;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
`ifdef MEM_TIMEOUT_EN
   logic        mem_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mem_wb_t sb[$];

   bit resp_auto = 1'b0;
   int resp_wait = 1;
   int req_seen = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_mem_i     (ex_mem),
      .mem_wb_o     (mem_wb),
      .mem_stall_o  (mem_stall),
      .dmem_req_o   (dmem_req),
      .dmem_we_o    (dmem_we),
      .dmem_addr_o  (dmem_addr),
      .dmem_wdata_o (dmem_wdata),
      .dmem_rdata_i (dmem_rdata),
      .dmem_rvalid_i(dmem_rvalid)
`ifdef MEM_TIMEOUT_EN
      ,
      .mem_err_o    (mem_err)
`endif
   );

   // 10 ns clock and a free-running cycle counter for latency measurements
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: 0x100 returns the test-plan pattern, and any other
   // address returns a value derived from that address.
   function automatic logic [31:0] resp_fn(input logic [31:0] addr);
      if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
      return addr ^ 32'h5A5A_0000;
   endfunction

   function automatic ex_mem_t mk_op(input logic v, input logic [31:0] alu,
                                     input logic [31:0] rs2, input logic [4:0] rd,
                                     input logic rw, input logic mr,
                                     input logic mw, input logic m2r);
      ex_mem_t op;
      op.valid = v; op.alu_result = alu; op.rs2_data = rs2; op.rd = rd;
      op.reg_write = rw; op.mem_read = mr; op.mem_write = mw; op.mem_to_reg = m2r;
      return op;
   endfunction

   function automatic mem_wb_t mk_wb(input logic [31:0] val, input logic [4:0] rd,
                                     input logic rw);
      mem_wb_t w;
      w.valid = 1'b1; w.alu_or_mem_val = val; w.rd = rd; w.reg_write = rw;
      return w;
   endfunction

   // Responder: while the automatic mode is on, it answers the Nth REQ cycle
   // of each transaction, where N is resp_wait.
   initial forever begin
      @(posedge clk); #1;
      if (resp_auto) begin
         if (dmem_req) begin
            req_seen++;
            if (req_seen == resp_wait) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = resp_fn(dmem_addr);
            end else begin
               dmem_rvalid = 1'b0;
            end
         end else begin
            req_seen    = 0;
            dmem_rvalid = 1'b0;
         end
      end
   end

   // Monitor: each retirement must match the head of the scoreboard, and a
   // bubble must never carry a register write.
   initial forever begin
      mem_wb_t exp;
      @(negedge clk);
      if (rst_n) begin
         checks++;
         if (mem_wb.valid === 1'b1) begin
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL retire_unexpected: got %h, none expected", mem_wb);
            end else begin
               exp = sb.pop_front();
               if (mem_wb !== exp) begin
                  errors++;
                  $display("[TB] FAIL retire_value: got %h expected %h", mem_wb, exp);
               end
            end
         end else if (mem_wb.reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bubble_reg_write: got %b expected 0", mem_wb.reg_write);
         end
      end
   end

   // Presents one op and holds it until the stage accepts it (stall low at
   // the negedge). Entered and left at posedge+1.
   task automatic issue_op(input ex_mem_t op, input mem_wb_t exp, output int stalls);
      stalls = 0;
      ex_mem = op;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!mem_stall) break;
         stalls++;
      end
      if (mem_stall) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: stall still %b after 64 cycles, expected 0", mem_stall);
      end
      sb.push_back(exp);
      @(posedge clk); #1;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
      dmem_rvalid = 1'b0;
      dmem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_wb !== '0) begin errors++; $display("[TB] FAIL reset_mem_wb: got %h expected 0", mem_wb); end
      checks++;
      if ({dmem_req, dmem_we} !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_we: got %b expected 00", {dmem_req, dmem_we}); end
      checks++;
      if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr_wdata: got %h/%h expected 0/0", dmem_addr, dmem_wdata); end
      checks++;
      if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", mem_stall); end
`ifdef MEM_TIMEOUT_EN
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_err: got %b expected 0", mem_err); end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alu();
      int st;
      int t0;
      resp_auto = 1'b1;
      t0 = cyc;
      issue_op(mk_op(1, 32'h0000_1234, 32'h0, 5, 1, 0, 0, 0), mk_wb(32'h0000_1234, 5, 1), st);
      checks++;
      if (st != 0) begin errors++; $display("[TB] FAIL alu_stall: got %0d stall cycles expected 0", st); end
      issue_op(mk_op(1, 32'hFFFF_0001, 32'h0, 6, 0, 0, 0, 1), mk_wb(32'hFFFF_0001, 6, 0), st);
      checks++;
      if (st != 0) begin errors++; $display("[TB] FAIL alu_stall_nowrite: got %0d expected 0", st); end
      checks++;
      if (cyc - t0 != 2) begin errors++; $display("[TB] FAIL alu_latency: got %0d cycles expected 2", cyc - t0); end
      @(negedge clk);
      checks++;
      if (mem_wb !== mk_wb(32'hFFFF_0001, 6, 0)) begin errors++; $display("[TB] FAIL alu_result: got %h expected %h", mem_wb, mk_wb(32'hFFFF_0001, 6, 0)); end
      @(posedge clk); #1;
   endtask

   task automatic test_bubble();
      ex_mem = mk_op(0, 32'hFFFF_FFFF, 32'h1111_1111, 31, 1, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL bubble_stall_req: got %b%b expected 00", mem_stall, dmem_req);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (mem_wb.valid !== 1'b0 || mem_wb.reg_write !== 1'b0) begin
         errors++; $display("[TB] FAIL bubble_out: got v=%b rw=%b expected 0/0", mem_wb.valid, mem_wb.reg_write);
      end
      @(posedge clk); #1;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_load();
      int stalls = 0;
      int reqs = 0;
      bit fields_ok = 1'b1;
      resp_auto = 1'b1;
      resp_wait = 3;
      ex_mem = mk_op(1, 32'h0000_0100, 32'h0, 7, 1, 1, 0, 1);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (dmem_req === 1'b1) begin
            reqs++;
            if (dmem_addr !== 32'h100 || dmem_we !== 1'b0) fields_ok = 1'b0;
         end
         if (!mem_stall) break;
         stalls++;
      end
      sb.push_back(mk_wb(32'hDEAD_BEEF, 7, 1));
      @(posedge clk); #1;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (stalls != 3) begin errors++; $display("[TB] FAIL load_stall_cycles: got %0d expected 3", stalls); end
      checks++;
      if (reqs != 3) begin errors++; $display("[TB] FAIL load_req_cycles: got %0d expected 3", reqs); end
      checks++;
      if (!fields_ok) begin errors++; $display("[TB] FAIL load_req_fields: got addr/we not held at 0x100/0, expected held"); end
      @(negedge clk);
      checks++;
      if (mem_wb !== mk_wb(32'hDEAD_BEEF, 7, 1) || dmem_req !== 1'b0) begin
         errors++; $display("[TB] FAIL load_retire: got %h req=%b expected %h req=0", mem_wb, dmem_req, mk_wb(32'hDEAD_BEEF, 7, 1));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      int stalls = 0;
      bit fields_ok = 1'b0;
      resp_auto = 1'b1;
      resp_wait = 1;
      ex_mem = mk_op(1, 32'h0000_0203, 32'hA5A5_A5A5, 12, 1, 0, 1, 0);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (dmem_req === 1'b1)
            fields_ok = (dmem_addr === 32'h200) && (dmem_we === 1'b1) && (dmem_wdata === 32'hA5A5_A5A5);
         if (!mem_stall) break;
         stalls++;
      end
      sb.push_back(mk_wb(32'h0000_0200, 12, 0));
      @(posedge clk); #1;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (!fields_ok) begin errors++; $display("[TB] FAIL store_req_fields: got %h/%b/%h expected 200/1/a5a5a5a5", dmem_addr, dmem_we, dmem_wdata); end
      checks++;
      if (stalls != 1) begin errors++; $display("[TB] FAIL store_latency: got %0d stall cycles expected 1", stalls); end
      @(negedge clk);
      checks++;
      if (mem_wb.valid !== 1'b1 || mem_wb.reg_write !== 1'b0) begin
         errors++; $display("[TB] FAIL store_retire: got v=%b rw=%b expected 1/0", mem_wb.valid, mem_wb.reg_write);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int st;
      int t0;
      resp_auto = 1'b1;
      t0 = cyc;
      resp_wait = 2;
      issue_op(mk_op(1, 32'h0000_0300, 32'h0, 8, 1, 1, 0, 1), mk_wb(resp_fn(32'h300), 8, 1), st);
      checks++;
      if (st != 2) begin errors++; $display("[TB] FAIL b2b_load1_stalls: got %0d expected 2", st); end
      resp_wait = 1;
      issue_op(mk_op(1, 32'h0000_0305, 32'h0, 9, 1, 1, 1, 1), mk_wb(resp_fn(32'h304), 9, 1), st);
      checks++;
      if (st != 1) begin errors++; $display("[TB] FAIL b2b_load2_stalls: got %0d expected 1", st); end
      issue_op(mk_op(1, 32'h0BAD_F00D, 32'h0, 10, 1, 0, 0, 0), mk_wb(32'h0BAD_F00D, 10, 1), st);
      checks++;
      if (cyc - t0 != 6) begin errors++; $display("[TB] FAIL b2b_total_cycles: got %0d expected 6", cyc - t0); end
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_stray_rvalid();
      int st;
      resp_auto = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'h1234_5678;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (dmem_req !== 1'b0 || mem_wb.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stray_rvalid: got req=%b v=%b expected 0/0", dmem_req, mem_wb.valid);
         end
         @(posedge clk); #1;
      end
      issue_op(mk_op(1, 32'h0000_0055, 32'h0, 3, 1, 0, 0, 0), mk_wb(32'h0000_0055, 3, 1), st);
      dmem_rvalid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_req();
      resp_auto = 1'b0;
      dmem_rvalid = 1'b0;
      ex_mem = mk_op(1, 32'h0000_0400, 32'h0, 9, 1, 1, 0, 1);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_launch: got %b expected 1", dmem_req); end
      rst_n = 1'b0;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || mem_wb.valid !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_in_req_drop: got req=%b v=%b expected 0/0", dmem_req, mem_wb.valid);
      end
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_wb.valid !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_late_rvalid: got v=%b req=%b expected 0/0", mem_wb.valid, dmem_req);
      end
      @(posedge clk); #1;
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int stalls = 0;
      int reqs = 0;
      int st;
      resp_auto = 1'b0;
      dmem_rvalid = 1'b0;
      ex_mem = mk_op(1, 32'h0000_0500, 32'h0, 11, 1, 1, 0, 1);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (dmem_req === 1'b1) reqs++;
         if (!mem_stall) break;
         stalls++;
      end
      sb.push_back(mk_wb(32'h0, 11, 0));
      @(posedge clk); #1;
      ex_mem = mk_op(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (reqs != 4) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 4", reqs); end
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || mem_err !== 1'b1) begin
         errors++; $display("[TB] FAIL timeout_abort: got req=%b err=%b expected 0/1", dmem_req, mem_err);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", mem_err); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      resp_auto = 1'b1;
      resp_wait = 4;
      issue_op(mk_op(1, 32'h0000_0600, 32'h0, 13, 1, 1, 0, 1), mk_wb(resp_fn(32'h600), 13, 1), st);
      checks++;
      if (st != 4) begin errors++; $display("[TB] FAIL timeout_late_resp_stalls: got %0d expected 4", st); end
      @(negedge clk);
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_late_resp_err: got %b expected 0", mem_err); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] mem_stage bench start");
      test_reset();
      test_alu();
      test_bubble();
      test_load();
      test_store();
      test_back_to_back();
      test_stray_rvalid();
      test_reset_in_req();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer of the EX/MEM pipeline register and producer of the MEM/WB pipeline register in the 5-stage pipeline.
- ALU-only instructions pass to writeback with 1-cycle latency.
- Loads and stores run a request/response transaction on the data-memory port.
- While a transaction is outstanding, the block stalls the upstream stages and inserts bubbles toward writeback.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in REQ before an outstanding access is aborted. Used only when MEM_TIMEOUT_EN is defined; minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ex_mem_i  input  74  EX/MEM register contents, ex_mem_t packed struct.
- mem_wb_o  output  39  MEM/WB register, mem_wb_t packed struct; registered.
- mem_stall_o  output  1  holds EX/MEM and all earlier stages; combinational.
- dmem_req_o  output  1  data-memory request; registered.
- dmem_we_o  output  1  1 = store, 0 = load; registered.
- dmem_addr_o  output  32  word address, alu_result with bits [1:0] forced to 0; registered.
- dmem_wdata_o  output  32  store data (ex_mem rs2); registered.
- dmem_rdata_i  input  32  load data; sampled only when dmem_rvalid_i=1.
- dmem_rvalid_i  input  1  1-cycle response pulse; serves as read-data valid and as write acknowledge.
- mem_err_o  output  1  sticky timeout flag; present only with MEM_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - On a rising edge with rst_n=0: FSM goes to IDLE; mem_wb_o is all-zero (valid=0, reg_write=0); dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o are 0; the timeout counter and mem_err_o are 0.
- A memory op is ex_mem_i.valid & (mem_read | mem_write). If mem_read and mem_write are both 1, the access is treated as a load.
- FSM states: IDLE, REQ.
- IDLE, no memory op:
  - Next edge, mem_wb_o loads valid=ex_mem_i.valid, alu_or_mem_val=alu_result, rd, reg_write=reg_write & valid.
  - mem_stall_o=0.
- IDLE, memory op present:
  - mem_stall_o=1.
  - Next edge:
    - latch we/addr/wdata, rd, reg_write and mem_to_reg into the request registers;
    - dmem_req_o=1;
    - mem_wb_o.valid=0 (bubble);
    - go to REQ.
- REQ, dmem_rvalid_i=0:
  - dmem_req_o and all latched request fields stay stable; mem_stall_o=1; mem_wb_o.valid=0.
- REQ, dmem_rvalid_i=1:
  - mem_stall_o=0 in that same cycle, so upstream advances on the same edge.
  - Next edge:
    - dmem_req_o=0; go to IDLE;
    - mem_wb_o.valid=1, rd = latched rd;
    - load: alu_or_mem_val = dmem_rdata_i, reg_write = latched reg_write;
    - store: alu_or_mem_val = latched address, reg_write=0.
- Latency:
  - ALU op: 1 cycle.
  - Memory op: 2 cycles minimum (rvalid in the first REQ cycle), plus 1 cycle per extra wait cycle.
- Back-to-back memory ops: the IDLE cycle after REQ launches the next op. Minimum throughput is 1 memory op per 2 cycles.
- dmem_rvalid_i while in IDLE is ignored. This covers stray responses and responses arriving after reset.
- Reset during REQ: the transaction is dropped and dmem_req_o=0 after the reset edge. No mem_wb_o write occurs for the dropped op.
- ex_mem_i.valid=0 always produces a bubble (mem_wb_o.valid=0, reg_write=0), whatever the other fields contain.
- The block never modifies ex_mem_i; while mem_stall_o=1, upstream guarantees ex_mem_i is held stable.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without rvalid.
  - When it reaches TIMEOUT_CYCLES-1 with no rvalid, next edge:
    - go to IDLE; dmem_req_o=0;
    - mem_wb_o.valid=1, reg_write=0, alu_or_mem_val=0;
    - mem_err_o=1, sticky until reset.
  - If rvalid arrives in the timeout cycle, the normal response wins and mem_err_o is not set.
- Not defined: no counter and no mem_err_o port; REQ waits indefinitely.

Test Plan:
- ALU op (valid=1, alu_result=0x0000_1234, rd=5, reg_write=1) -> after 1 edge: mem_wb_o={1, 0x1234, 5, 1}; mem_stall_o=0 throughout.
- Load (addr 0x100, rd=7), dmem_rdata_i=0xDEAD_BEEF returned after 3 REQ cycles ->
  - dmem_req_o=1, dmem_addr_o=0x100, dmem_we_o=0 for those 3 cycles;
  - mem_stall_o=1 for 3 cycles;
  - mem_wb_o={1, 0xDEADBEEF, 7, 1} on the edge after rvalid.
- Store (addr 0x203, rs2=0xA5A5_A5A5), rvalid in first REQ cycle ->
  - dmem_addr_o=0x200, dmem_we_o=1, dmem_wdata_o=0xA5A5A5A5;
  - retires with reg_write=0 after 2 cycles total.
- Back-to-back load, load, ALU op -> bubbles only during REQ; all three retire in order with correct rd; the next op launches in the IDLE cycle after each REQ.
- rst_n=0 for 1 cycle during REQ, then rvalid=1 ->
  - after reset: dmem_req_o=0, mem_wb_o.valid=0;
  - the late rvalid produces no writeback.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no rvalid ->
  - after 4 REQ cycles: dmem_req_o=0, mem_wb_o={1, 0, rd, 0}, mem_err_o=1 and it stays 1;
  - a repeat run with rvalid in the 4th REQ cycle -> normal data, mem_err_o=0.
